// File: rtl/spi_slave_wb.sv
// spi_slave_wb: SPI mode-0 slave that turns command/data frames into
// Wishbone single-beat reads and writes with address auto-increment.
module spi_slave_wb #(
   parameter int WB_TIMEOUT = 15
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       sck_i,
   input  logic       ss_n_i,
   input  logic       mosi_i,
   output logic       miso_o,
   output logic       miso_oe,
   output logic [7:0] wb_addr_o,
   output logic [7:0] wb_data_o,
   input  logic [7:0] wb_data_i,
   output logic       wb_we_o,
   output logic       wb_cyc_o,
   output logic       wb_stb_o,
   input  logic       wb_ack_i,
   input  logic       wb_err_i,
   output logic       err_o
);

   localparam int TW = $clog2(WB_TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(WB_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_e;
   typedef enum logic {WB_IDLE, WB_BUSY} wb_state_e;

   // synchronizer chains: [0] meta, [1] synced, [2] previous synced
   logic [2:0] sck_s_q, sck_s_d;
   logic [2:0] ss_s_q, ss_s_d;
   logic [1:0] mosi_s_q, mosi_s_d;

   logic sck_rise, sck_fall, ss_fall, ss_rise;

   spi_state_e spi_state_q, spi_state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] tx_q, tx_d;
   logic [6:0] addr_q, addr_d;
   logic       wr_mode_q, wr_mode_d;
   logic       load_q, load_d;
   logic [7:0] rx_byte;

   logic       req_vld;
   logic       req_we;
   logic [6:0] req_addr;
   logic [7:0] req_data;
   logic       spi_err;

   wb_state_e  wb_state_q, wb_state_d;
   logic          cyc_q, cyc_d;
   logic          we_q, we_d;
   logic [6:0]    adr_q, adr_d;
   logic [7:0]    dat_q, dat_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          rd_valid_q, rd_valid_d;
   logic          rd_live_q, rd_live_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          wb_fail;
   logic          wb_drop;
   logic          wb_term;
   logic          wb_ok;
   logic          new_rd;

   logic err_q, err_d;

   // bring the asynchronous SPI pins into the wb_clk_i domain
   always_comb begin
      sck_s_d  = {sck_s_q[1:0], sck_i};
      ss_s_d   = {ss_s_q[1:0], ss_n_i};
      mosi_s_d = {mosi_s_q[0], mosi_i};
   end

   assign sck_rise = sck_s_q[1] & ~sck_s_q[2];
   assign sck_fall = ~sck_s_q[1] & sck_s_q[2];
   assign ss_fall  = ~ss_s_q[1] & ss_s_q[2];
   assign ss_rise  = ss_s_q[1] & ~ss_s_q[2];
   assign rx_byte  = {rx_q[6:0], mosi_s_q[1]};

   // synchronizer registers
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sck_s_q  <= '0;
         ss_s_q   <= '0;
         mosi_s_q <= '0;
      end else begin
         sck_s_q  <= sck_s_d;
         ss_s_q   <= ss_s_d;
         mosi_s_q <= mosi_s_d;
      end
   end

   // SPI frame decode: shift bits, classify bytes, raise bus requests
   always_comb begin
      spi_state_d = spi_state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      addr_d      = addr_q;
      wr_mode_d   = wr_mode_q;
      load_d      = load_q;
      req_vld     = 1'b0;
      req_we      = 1'b0;
      req_addr    = addr_q;
      req_data    = rx_byte;
      spi_err     = 1'b0;
      if (ss_rise) begin
         spi_state_d = IDLE;
         load_d      = 1'b0;
      end else if (ss_fall) begin
         spi_state_d = CMD;
         bit_cnt_d   = 3'd0;
         tx_d        = 8'h00;
         load_d      = 1'b0;
      end else if (spi_state_q != IDLE) begin
         if (sck_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               unique case (spi_state_q)
                  CMD: begin
                     spi_state_d = DATA;
                     wr_mode_d   = rx_byte[7];
                     addr_d      = rx_byte[6:0];
                     if (!rx_byte[7]) begin
                        req_vld  = 1'b1;
                        req_addr = rx_byte[6:0];
                        load_d   = 1'b1;
                     end
                  end
                  DATA: begin
                     addr_d  = addr_q + 7'd1;
                     req_vld = 1'b1;
                     if (wr_mode_q) begin
                        req_we   = 1'b1;
                        req_addr = addr_q;
                     end else begin
                        req_addr = addr_q + 7'd1;
                        load_d   = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end else if (sck_fall) begin
            if (load_q) begin
               tx_d    = rd_valid_q ? rd_data_q : 8'hFF;
               spi_err = ~rd_valid_q;
               load_d  = 1'b0;
            end else begin
               tx_d = {tx_q[6:0], 1'b0};
            end
         end
      end
   end

   // SPI state and shift registers
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         spi_state_q <= IDLE;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         addr_q      <= '0;
         wr_mode_q   <= 1'b0;
         load_q      <= 1'b0;
      end else begin
         spi_state_q <= spi_state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         addr_q      <= addr_d;
         wr_mode_q   <= wr_mode_d;
         load_q      <= load_d;
      end
   end

   assign new_rd  = req_vld & ~req_we;
   assign wb_term = wb_ack_i | wb_err_i | (tmr_q == T_LAST);
   assign wb_ok   = wb_ack_i & ~wb_err_i;

   // Wishbone master: one outstanding cycle, timeout, read-data capture
   always_comb begin
      wb_state_d = wb_state_q;
      cyc_d      = cyc_q;
      we_d       = we_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      tmr_d      = tmr_q;
      rd_valid_d = rd_valid_q;
      rd_live_d  = rd_live_q;
      rd_data_d  = rd_data_q;
      wb_fail    = 1'b0;
      wb_drop    = 1'b0;
      if (new_rd) begin
         rd_valid_d = 1'b0;
         rd_live_d  = 1'b0;
      end
      unique case (wb_state_q)
         WB_IDLE: begin
            if (req_vld) begin
               wb_state_d = WB_BUSY;
               cyc_d      = 1'b1;
               we_d       = req_we;
               adr_d      = req_addr;
               dat_d      = req_we ? req_data : 8'h00;
               tmr_d      = '0;
               rd_live_d  = ~req_we;
            end
         end
         WB_BUSY: begin
            wb_drop = req_vld;
            if (wb_term) begin
               wb_state_d = WB_IDLE;
               cyc_d      = 1'b0;
               wb_fail    = ~wb_ok;
               if (!we_q && rd_live_q && !new_rd) begin
                  rd_valid_d = 1'b1;
                  rd_live_d  = 1'b0;
                  rd_data_d  = wb_ok ? wb_data_i : 8'hFF;
               end
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         default: ;
      endcase
   end

   // Wishbone state and bus registers
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wb_state_q <= WB_IDLE;
         cyc_q      <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
         tmr_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_live_q  <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         wb_state_q <= wb_state_d;
         cyc_q      <= cyc_d;
         we_q       <= we_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         tmr_q      <= tmr_d;
         rd_valid_q <= rd_valid_d;
         rd_live_q  <= rd_live_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // sticky error: cleared by a new frame, any fault in the same cycle wins
   always_comb begin
      err_d = err_q;
      if (ss_fall) begin
         err_d = 1'b0;
      end
      if (spi_err || wb_fail || wb_drop) begin
         err_d = 1'b1;
      end
   end

   // error flag register
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign miso_oe   = ~ss_s_q[1] & (spi_state_q != IDLE);
   assign miso_o    = miso_oe & tx_q[7];
   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = cyc_q;
   assign wb_we_o   = we_q;
   assign wb_addr_o = {1'b0, adr_q};
   assign wb_data_o = dat_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_spi_slave_wb.sv
// tb_spi_slave_wb: randomized SPI frames against a frame-level model,
// with scoreboards for Wishbone accesses and MISO bytes.
`timescale 1ns/1ps
module tb_spi_slave_wb;

   localparam int HALF = 80;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sck = 1'b0;
   logic       ss_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso_o, miso_oe;
   logic [7:0] wb_addr_o, wb_data_o;
   logic [7:0] wb_data_i = 8'h00;
   logic       wb_we_o, wb_cyc_o, wb_stb_o;
   logic       wb_ack_i = 1'b0;
   logic       wb_err_i = 1'b0;
   logic       err_o;

   typedef struct packed {
      logic       we;
      logic [6:0] addr;
      logic [7:0] data;
   } acc_t;

   acc_t       exp_wb[$];
   logic [7:0] exp_miso[$];
   logic [7:0] obs_miso[$];
   logic [7:0] slave_mem[128];
   logic [7:0] ref_mem[128];
   logic [7:0] fd[8];

   int  checks = 0;
   int  passes = 0;
   int  last_len = 0;
   bit  no_ack = 0;
   bit  err_mode = 0;
   bit  rd_ok = 1;

   always #5 clk = ~clk;

   spi_slave_wb #(.WB_TIMEOUT(15)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .sck_i    (sck),
      .ss_n_i   (ss_n),
      .mosi_i   (mosi),
      .miso_o   (miso_o),
      .miso_oe  (miso_oe),
      .wb_addr_o(wb_addr_o),
      .wb_data_o(wb_data_o),
      .wb_data_i(wb_data_i),
      .wb_we_o  (wb_we_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_ack_i (wb_ack_i),
      .wb_err_i (wb_err_i),
      .err_o    (err_o)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act === want) passes++;
      else $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
   endtask

   // Wishbone slave: random 0..2 wait states, optional no-ack / error
   initial begin
      int lat = 0;
      int wcnt = 0;
      forever begin
         @(negedge clk);
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         if (wb_cyc_o && wb_stb_o && !rst) begin
            if (wcnt < lat) begin
               wcnt++;
            end else if (err_mode) begin
               wb_err_i = 1'b1;
               wb_data_i = 8'($urandom);
               wcnt = 0;
               lat = $urandom_range(0, 2);
            end else if (!no_ack) begin
               wb_ack_i = 1'b1;
               if (wb_we_o) slave_mem[wb_addr_o[6:0]] = wb_data_o;
               wb_data_i = slave_mem[wb_addr_o[6:0]];
               wcnt = 0;
               lat = $urandom_range(0, 2);
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // Wishbone monitor: pop the expected access when a cycle opens
   initial begin
      acc_t cur;
      bit   prev;
      int   len;
      cur = '0;
      prev = 0;
      len = 0;
      forever begin
         @(negedge clk);
         #1;
         if (wb_cyc_o && !prev) begin
            chk("wb_expected_pending", 32'(exp_wb.size() != 0), 1);
            if (exp_wb.size() != 0) cur = exp_wb.pop_front();
            chk("wb_stb", wb_stb_o, 1);
            len = 0;
         end
         if (wb_cyc_o) begin
            len++;
            chk("wb_addr", wb_addr_o, {1'b0, cur.addr});
            chk("wb_we", wb_we_o, cur.we);
            if (cur.we) chk("wb_wdata", wb_data_o, cur.data);
         end else if (prev) begin
            last_len = len;
         end
         prev = wb_cyc_o;
      end
   end

   // MISO monitor: compare each captured byte with the model
   initial begin
      logic [7:0] g;
      forever begin
         @(negedge clk);
         if (obs_miso.size() > 0) begin
            g = obs_miso.pop_front();
            chk("miso_pending", 32'(exp_miso.size() != 0), 1);
            if (exp_miso.size() != 0) chk("miso_byte", g, exp_miso.pop_front());
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, got timeout want done");
      $fatal(1);
   end

   task automatic set_mem(input int a, input logic [7:0] d);
      slave_mem[a] = d;
      ref_mem[a] = d;
   endtask

   task automatic ss_start();
      ss_n = 1'b0;
      #HALF;
      chk("oe_active", miso_oe, 1);
      chk("err_clear", err_o, 0);
   endtask

   task automatic ss_end();
      #HALF;
      ss_n = 1'b1;
      #(HALF * 4);
   endtask

   task automatic xfer(input logic [7:0] b, input int nbits);
      logic [7:0] g;
      g = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = b[7-i];
         #HALF;
         g[7-i] = miso_o;
         sck = 1'b1;
         #HALF;
         sck = 1'b0;
      end
      if (nbits == 8) obs_miso.push_back(g);
   endtask

   // reference model of one frame, then drive it
   task automatic run_frame(input logic [7:0] cmd, input int n);
      int   st;
      acc_t e;
      st = int'(cmd[6:0]);
      exp_miso.push_back(8'h00);
      if (cmd[7]) begin
         for (int i = 0; i < n; i++) begin
            e.we = 1'b1;
            e.addr = 7'((st + i) % 128);
            e.data = fd[i];
            exp_wb.push_back(e);
            ref_mem[(st + i) % 128] = fd[i];
            exp_miso.push_back(8'h00);
         end
      end else begin
         for (int i = 0; i <= n; i++) begin
            e.we = 1'b0;
            e.addr = 7'((st + i) % 128);
            e.data = 8'h00;
            exp_wb.push_back(e);
         end
         for (int i = 0; i < n; i++)
            exp_miso.push_back(rd_ok ? ref_mem[(st + i) % 128] : 8'hFF);
      end
      ss_start();
      xfer(cmd, 8);
      for (int i = 0; i < n; i++) xfer(fd[i], 8);
      ss_end();
   endtask

   initial begin
      int n;
      logic [7:0] cmd;
      for (int i = 0; i < 128; i++) set_mem(i, 8'($urandom));
      repeat (4) @(negedge clk);
      chk("rst_cyc", wb_cyc_o, 0);
      chk("rst_stb", wb_stb_o, 0);
      chk("rst_we", wb_we_o, 0);
      chk("rst_addr", wb_addr_o, 0);
      chk("rst_data", wb_data_o, 0);
      chk("rst_miso", miso_o, 0);
      chk("rst_oe", miso_oe, 0);
      chk("rst_err", err_o, 0);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      fd[0] = 8'hA5; fd[1] = 8'h5A;
      run_frame(8'h85, 2);
      chk("wr_err", err_o, 0);

      set_mem(16, 8'h3C); set_mem(17, 8'hC3);
      fd[0] = 8'h00; fd[1] = 8'h00;
      run_frame(8'h10, 2);
      chk("rd_err", err_o, 0);

      fd[0] = 8'h11; fd[1] = 8'h22;
      run_frame(8'hFF, 2);
      chk("wrap_err", err_o, 0);

      no_ack = 1; rd_ok = 0;
      run_frame(8'h10, 2);
      chk("timeout_len", last_len, 15);
      repeat (20) @(negedge clk);
      chk("timeout_err_sticky", err_o, 1);
      no_ack = 0; rd_ok = 1;

      err_mode = 1; rd_ok = 0;
      run_frame(8'h20, 1);
      chk("buserr_err", err_o, 1);
      err_mode = 0; rd_ok = 1;

      exp_miso.push_back(8'h00);
      ss_start();
      xfer(8'h85, 8);
      xfer(8'hF0, 4);
      ss_end();
      chk("abort_oe", miso_oe, 0);
      chk("abort_miso", miso_o, 0);
      chk("abort_err", err_o, 0);

      fd[0] = 8'h77;
      run_frame(8'h85, 1);

      no_ack = 1;
      exp_miso.push_back(8'h00);
      exp_wb.push_back('{we: 1'b0, addr: 7'h30, data: 8'h00});
      ss_start();
      xfer(8'h30, 8);
      for (int i = 0; i < 50 && !wb_cyc_o; i++) @(negedge clk);
      chk("rst_test_busy", wb_cyc_o, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_cyc", wb_cyc_o, 0);
      chk("arst_stb", wb_stb_o, 0);
      chk("arst_addr", wb_addr_o, 0);
      chk("arst_oe", miso_oe, 0);
      chk("arst_err", err_o, 0);
      @(negedge clk);
      rst = 1'b0;
      no_ack = 0;
      repeat (6) @(negedge clk);
      chk("post_rst_idle_oe", miso_oe, 0);
      ss_n = 1'b1;
      #(HALF * 4);

      for (int f = 0; f < 10; f++) begin
         n = $urandom_range(1, 4);
         cmd = 8'($urandom);
         if (f % 4 == 3) cmd[6:0] = 7'h7E;
         for (int i = 0; i < n; i++) fd[i] = 8'($urandom);
         run_frame(cmd, n);
         chk("rand_err", err_o, 0);
      end

      repeat (20) @(negedge clk);
      chk("wb_queue_empty", exp_wb.size(), 0);
      chk("miso_queue_empty", exp_miso.size(), 0);
      chk("obs_queue_empty", obs_miso.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
